// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full-flag logic of an asynchronous FIFO, entirely in the wr_clk domain.
// Optional registered almost-full flag is enabled with `define FIFO_WPTR_ALMOST_FULL_EN.
module fifo_wptr_full #(
  parameter int FIFO_addr = 5,
  parameter int AF_THRESH = 12
) (
  input  logic                 wr_clk,
  input  logic                 wr_reset,
  input  logic                 wr_en,
  input  logic [FIFO_addr-1:0] rd_ptr_gr_syn,
  output logic [FIFO_addr-1:0] wr_ptr,
  output logic [FIFO_addr-1:0] wr_ptr_gr,
  output logic                 wr_mem_en,
  output logic                 wr_full,
  output logic [FIFO_addr-1:0] wr_level,
  output logic                 wr_overflow,
  output logic                 wr_almost_full
);

  localparam int MSB   = FIFO_addr - 1;
  localparam int DEPTH = 1 << (FIFO_addr - 1);

  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_af_thresh_check
    $error("fifo_wptr_full: AF_THRESH out of range 1..DEPTH");
  end

  logic [MSB:0] rd_bin;
  logic [MSB:0] wr_ptr_next;
  logic [MSB:0] level_next;
  logic         full_c;
  logic         accept;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rd_bin = '0;
    for (int i = 0; i <= MSB; i++) begin
      rd_bin[i] = ^(rd_ptr_gr_syn >> i);
    end
  end

  // wr_en is a request; it is accepted (and strobes memory) only while not full.
  assign full_c      = (wr_ptr[MSB] != rd_bin[MSB]) && (wr_ptr[MSB-1:0] == rd_bin[MSB-1:0]);
  assign accept      = wr_en && !full_c;
  assign wr_mem_en   = accept;
  assign wr_ptr_next = wr_ptr + {{MSB{1'b0}}, accept};
  assign level_next  = wr_ptr_next - rd_bin;
  assign wr_ptr_gr   = wr_ptr ^ (wr_ptr >> 1);

  always_ff @(posedge wr_clk) begin
    if (wr_reset) begin
      wr_ptr      <= '0;
      wr_full     <= 1'b0;
      wr_level    <= '0;
      wr_overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_next;
      wr_full  <= full_c;
      wr_level <= level_next;
      if (wr_en && full_c) begin
        wr_overflow <= 1'b1;
      end
    end
  end

`ifdef FIFO_WPTR_ALMOST_FULL_EN
  localparam logic [MSB:0] AF_T = FIFO_addr'(AF_THRESH);

  always_ff @(posedge wr_clk) begin
    if (wr_reset) begin
      wr_almost_full <= 1'b0;
    end else begin
      wr_almost_full <= (level_next >= AF_T);
    end
  end
`else
  assign wr_almost_full = 1'b0;
`endif

endmodule
